// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the EX stage. Implements MULT, MULTU,
//   DIV and DIVU with architectural HI/LO registers. One operation at a time;
//   busy_o stays high while the datapath iterates so the hazard logic can
//   stall dependent MFHI/MFLO and any later mult/div. An optional
//   single-cycle multiplier (MUL_FAST=1) bypasses the iteration for multiplies.
//
// Ports
//   clk_i     clock, rising edge
//   rst_n_i   asynchronous active-low reset
//   start_i   issue operation (accepted only while idle)
//   op_i      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_i      multiplicand / dividend
//   rt_i      multiplier / divisor
//   flush_i   abort the in-flight operation, or drop a same-cycle start
//   hi_we_i   MTHI write enable (honoured when not busy)
//   lo_we_i   MTLO write enable (honoured when not busy)
//   wdata_i   MTHI/MTLO data
//   busy_o    operation in flight
//   done_o    one-cycle pulse in the cycle after HI/LO take a result
//   hi_o      HI register
//   lo_o      LO register
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            flush_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [2*XLEN-1:0]   acc_reg;       // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     opnd_reg;      // multiplicand magnitude or divisor magnitude
    logic                is_div_reg;
    logic                neg_res_reg;   // negate product / quotient
    logic                neg_rem_reg;   // negate remainder (dividend sign)
    logic                div_zero_reg;
    logic [XLEN-1:0]     hi_reg, lo_reg;

    // ---------------- operand conditioning ----------------
    logic            op_signed, rs_neg, rt_neg, fast_mul, accept;
    logic [XLEN-1:0] rs_mag, rt_mag;

    assign op_signed = ~op_i[0];
    assign rs_neg    = op_signed & rs_i[XLEN-1];
    assign rt_neg    = op_signed & rt_i[XLEN-1];
    assign rs_mag    = rs_neg ? -rs_i : rs_i;
    assign rt_mag    = rt_neg ? -rt_i : rt_i;
    assign fast_mul  = MUL_FAST && !op_i[1];
    assign accept    = (state_reg == S_IDLE) && start_i && !flush_i;

    // ---------------- single-cycle multiplier ----------------
    logic [2*XLEN-1:0] fast_product;

    generate
        if (MUL_FAST) begin : g_fast
            logic [2*XLEN-1:0] ext_a, ext_b;
            assign ext_a        = {{XLEN{rs_neg}}, rs_i};
            assign ext_b        = {{XLEN{rt_neg}}, rt_i};
            // Low 2*XLEN bits of the sign/zero-extended product are exact.
            assign fast_product = ext_a * ext_b;
        end else begin : g_slow
            assign fast_product = '0;
        end
    endgenerate

    // ---------------- iteration steps ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_fits;
    logic [2*XLEN-1:0] div_step;

    // Shift-add: add multiplicand to upper half when multiplier LSB is set,
    // then shift the whole accumulator right keeping the carry.
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                      (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide: shift next dividend bit into the remainder, subtract
    // the divisor when it fits. A zero divisor always fits, which leaves the
    // dividend in the remainder and all ones in the quotient.
    assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_fits  = ~div_diff[XLEN];
    assign div_step  = {(div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_reg[XLEN-2:0], div_fits};

    // ---------------- sign correction ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem, fix_hi, fix_lo;

    assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    assign quo      = acc_reg[XLEN-1:0];
    assign rem      = acc_reg[2*XLEN-1:XLEN];

    // Divide by zero forces LO to all ones; HI comes back as the original
    // rs because |rs| re-negated with the dividend sign restores it.
    always_comb begin
        fix_hi = prod_fix[2*XLEN-1:XLEN];
        fix_lo = prod_fix[XLEN-1:0];
        if (is_div_reg) begin
            fix_hi = neg_rem_reg ? -rem : rem;
            fix_lo = div_zero_reg ? '1 : (neg_res_reg ? -quo : quo);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = fast_mul ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)                              state_next = S_IDLE;
                else if (cnt_reg == CNT_W'(XLEN - 1))     state_next = S_FIX;
            end
            S_FIX:  state_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_reg == S_CALC) || (state_reg == S_FIX);
        done_o = (state_reg == S_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept && !fast_mul) begin
                        cnt_reg      <= '0;
                        acc_reg      <= {{XLEN{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
                        opnd_reg     <= op_i[1] ? rt_mag : rs_mag;
                        is_div_reg   <= op_i[1];
                        neg_res_reg  <= rs_neg ^ rt_neg;
                        neg_rem_reg  <= rs_neg;
                        div_zero_reg <= op_i[1] && (rt_i == '0);
                    end
                end
                S_CALC: begin
                    acc_reg <= is_div_reg ? div_step : mul_step;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO: results win over a same-cycle MTHI/MTLO; MT writes are only
    // honoured while not busy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == S_FIX && !flush_i) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
        end else if (accept && fast_mul) begin
            hi_reg <= fast_product[2*XLEN-1:XLEN];
            lo_reg <= fast_product[XLEN-1:0];
        end else if (state_reg == S_IDLE || state_reg == S_DONE) begin
            if (hi_we_i) hi_reg <= wdata_i;
            if (lo_we_i) lo_reg <= wdata_i;
        end
    end

    assign hi_o = hi_reg;
    assign lo_o = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Randomised and directed bench for muldiv_unit. A transaction-level model
//   (arithmetic results plus cycle counting) predicts busy/done/HI/LO every
//   cycle for the iterative instance; a second instance exercises the
//   single-cycle multiply option.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int LAT = 34;   // done cycle for an iterative op (XLEN+2)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // iterative instance
    logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0, rt = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    // single-cycle multiply instance
    logic        f_start = 1'b0, f_flush = 1'b0, f_hi_we = 1'b0, f_lo_we = 1'b0;
    logic [1:0]  f_op = 2'b00;
    logic [31:0] f_rs = '0, f_rt = '0, f_wdata = '0;
    logic        f_busy, f_done;
    logic [31:0] f_hi, f_lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_FAST(1'b0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .rs_i(rs), .rt_i(rt), .flush_i(flush), .hi_we_i(hi_we),
        .lo_we_i(lo_we), .wdata_i(wdata), .busy_o(busy), .done_o(done),
        .hi_o(hi), .lo_o(lo)
    );

    muldiv_unit #(.XLEN(32), .MUL_FAST(1'b1)) dut_fast (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(f_start), .op_i(f_op),
        .rs_i(f_rs), .rt_i(f_rt), .flush_i(f_flush), .hi_we_i(f_hi_we),
        .lo_we_i(f_lo_we), .wdata_i(f_wdata), .busy_o(f_busy), .done_o(f_done),
        .hi_o(f_hi), .lo_o(f_lo)
    );

    // ---------------- reference arithmetic ----------------
    // Returns {HI, LO} for an operation.
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb;
        int          sa, sb;
        logic [31:0] q, r;
        case (o)
            2'b00: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            2'b01: begin
                ea = {32'b0, a};
                eb = {32'b0, b};
                return ea * eb;
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b11) begin
                    q = a / b;
                    r = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    q  = sa / sb;
                    r  = sa % sb;
                end
                return {r, q};
            end
        endcase
    endfunction

    // ---------------- cycle model of the iterative instance ----------------
    // m_phase: 0 idle, 1..LAT-1 busy cycles since acceptance, LAT done cycle.
    int          m_phase = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    logic        m_busy, m_done;

    assign m_busy = (m_phase >= 1) && (m_phase <= LAT - 1);
    assign m_done = (m_phase == LAT);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
            m_pend  <= '0;
        end else if (m_phase >= 1 && m_phase <= LAT - 1) begin
            if (flush) begin
                m_phase <= 0;
            end else if (m_phase == LAT - 1) begin
                m_phase <= LAT;
                m_hi    <= m_pend[63:32];
                m_lo    <= m_pend[31:0];
            end else begin
                m_phase <= m_phase + 1;
            end
        end else begin
            if (hi_we) m_hi <= wdata;
            if (lo_we) m_lo <= wdata;
            if (m_phase == 0 && start && !flush) begin
                m_phase <= 1;
                m_pend  <= ref_result(op, rs, rt);
            end else begin
                m_phase <= 0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare the iterative instance
    // against the model.
    task automatic tick();
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("hi",   64'(hi),   64'(m_hi));
        chk("lo",   64'(lo),   64'(m_lo));
    endtask

    // Issue one op on the iterative instance, wait (bounded) for done and
    // compare against hand-computed values.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int busy_n;
        bit seen;
        op = o; rs = a; rt = b; start = 1'b1;
        tick();
        start = 1'b0;
        busy_n = busy ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        chk({nm, " done_seen"}, 64'(seen), 64'd1);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        chk({nm, " busy_cycles"}, 64'(busy_n), 64'd33);
        tick();
        chk({nm, " done_one_shot"}, 64'(done), 64'd0);
    endtask

    // Issue one op on the single-cycle-multiply instance.
    task automatic run_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input string nm);
        int busy_n;
        bit seen;
        f_op = o; f_rs = a; f_rt = b; f_start = 1'b1;
        tick();
        f_start = 1'b0;
        if (!o[1]) begin
            chk({nm, " done"}, 64'(f_done), 64'd1);
            chk({nm, " busy"}, 64'(f_busy), 64'd0);
            chk({nm, " hilo"}, {f_hi, f_lo}, exp);
            tick();
            chk({nm, " done_clear"}, 64'(f_done), 64'd0);
        end else begin
            busy_n = f_busy ? 1 : 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (f_done) seen = 1'b1;
                else if (f_busy) busy_n++;
            end
            chk({nm, " done_seen"}, 64'(seen), 64'd1);
            chk({nm, " busy_cycles"}, 64'(busy_n), 64'd33);
            chk({nm, " hilo"}, {f_hi, f_lo}, exp);
            tick();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) tick();
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, -32'd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        run_op(2'b10, -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        run_op(2'b10, -32'd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_neg");

        // MTLO, then a divide flushed in cycle 10; a restart is accepted at once.
        lo_we = 1'b1; wdata = 32'h1234;
        tick();
        lo_we = 1'b0;
        op = 2'b11; rs = 32'd100; rt = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush lo", 64'(lo), 64'h1234);
        chk("flush hi", 64'(hi), 64'hFFFF_FFFB);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_restart");

        // Reset in cycle 20 of a MULT.
        op = 2'b00; rs = 32'd12345; rt = -32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 3) == 0;
            op    = 2'($urandom);
            rs    = pick();
            rt    = pick();
            flush = ($urandom % 150) == 0;
            hi_we = ($urandom % 20) == 0;
            lo_we = ($urandom % 20) == 0;
            wdata = $urandom;
            tick();
        end
        start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) tick();

        // Single-cycle multiply option.
        run_fast(2'b01, 32'd6, 32'd7, 64'd42, "fast_multu");
        run_fast(2'b00, -32'd7, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, "fast_mult");
        for (int i = 0; i < 20; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = {1'b0, 1'($urandom)};
            a = pick();
            b = pick();
            run_fast(o, a, b, ref_result(o, a, b), "fast_rand");
        end
        run_fast(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, "fast_divu");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
